fifo_rd_unpacker: RTL and testbench

//  Drains the 128-bit synchronous FIFO and presents its words to the consumer as 32-bit beats.
//  - Sits directly downstream of the FIFO: drives its read enable, captures its read data.
//  - Beat order is least-significant first; output is a valid/ready stream.
//  - A 2-word holding buffer allows full-rate streaming despite the FIFO read latency.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_word_buf.sv | 46 ++++
 rtl/fifo_rd_unpacker.sv | 119 +++++++++++
 tb/tb_fifo_rd_unpacker.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, FSM state type and width-ratio helper for the FIFO read unpacker
package fifo_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int OUT_W_DEF  = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Number of output beats carried by one FIFO word.
  function automatic int ratio_of(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/fifo_word_buf.sv
// rtl/fifo_word_buf.sv - two-entry word holding buffer with write/read pointers and occupancy
module fifo_word_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_word,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_word,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Write at wr_ptr, retire at rd_ptr; a write and a pop together leave occupancy unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign rd_word = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_unpacker.sv
// rtl/fifo_rd_unpacker.sv - drains a wide synchronous FIFO and emits its words as narrow LSB-first beats
module fifo_rd_unpacker
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_empty,
  input  logic [DATA_W-1:0] i_rddata,
  output logic              o_rden,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_last,
  output logic              o_busy
);

  localparam int RATIO  = ratio_of(DATA_W, OUT_W);
  localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IW     = $clog2(RD_LAT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  logic [RD_LAT-1:0] pipe;
  logic [IW-1:0]     inflight;
  logic              cap;
  logic [2:0]        pending;
  logic [BEAT_W-1:0] beat;
  logic              hs;
  logic              pop;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        occ;
  state_t            state;
  state_t            state_nx;

  // Count read pulses issued but whose data has not yet been captured.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IW'(pipe[i]);
    end
  end

  assign cap     = pipe[RD_LAT-1];
  assign pending = 3'(occ) + 3'(inflight);
  // Only read when a buffer slot is guaranteed for the returning word; held off during reset.
  assign o_rden  = reset && !i_empty && (pending < 3'd2);
  assign hs      = o_valid && i_ready;
  assign pop     = hs && o_last;
  assign o_busy  = (occ != 2'd0) || (inflight != '0);

  // Delay line matching the FIFO read latency; its tail marks i_rddata as valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= o_rden;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  fifo_word_buf #(.DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cap),
    .wr_word (i_rddata),
    .pop     (pop),
    .rd_word (rd_word),
    .occ     (occ)
  );

  // Beat index within the current word; wraps after the last beat is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
    end else if (hs) begin
      beat <= o_last ? '0 : beat + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and beat presentation; data is zero whenever nothing is offered.
  always_comb begin
    state_nx = state;
    o_valid  = 1'b0;
    o_data   = '0;
    o_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cap) begin
          state_nx = S_SEND;
        end
      end
      S_SEND: begin
        o_valid = 1'b1;
        o_data  = rd_word[int'(beat)*OUT_W +: OUT_W];
        o_last  = (beat == LAST_BEAT);
        if (pop && (occ == 2'd1) && !cap) begin
          state_nx = S_IDLE;
        end
      end
    endcase
  end

  a_pending_bound: assert property (@(posedge clk) disable iff (!reset) pending <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb/tb_fifo_rd_unpacker.sv - randomized scoreboard bench for the FIFO read unpacker
module tb_fifo_rd_unpacker;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_empty;
  logic [127:0] i_rddata = '0;
  logic         o_rden;
  logic         o_valid;
  logic         i_ready;
  logic [31:0]  o_data;
  logic         o_last;
  logic         o_busy;

  int total = 0;
  int bad   = 0;
  int reads = 0;
  int done  = 0;

  logic [127:0] fifo_q [$];
  beat_t        exp_q  [$];

  logic         prev_stall = 1'b0;
  logic [31:0]  prev_data  = '0;
  logic         prev_last  = 1'b0;

  fifo_rd_unpacker dut (
    .clk      (clk),
    .reset    (reset),
    .i_empty  (i_empty),
    .i_rddata (i_rddata),
    .o_rden   (o_rden),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [127:0] w);
    fifo_q.push_back(w);
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.d = w[k*32 +: 32];
      b.l = (k == 3);
      exp_q.push_back(b);
    end
    i_empty = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || reads != done) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_time", n < budget, 1);
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural synchronous FIFO: one-cycle read latency.
  always @(posedge clk) begin
    if (reset && o_rden) begin
      if (fifo_q.size() == 0) begin
        chk("fifo_underflow", 0, 1);
      end else begin
        logic [127:0] w;
        w = fifo_q.pop_front();
        i_rddata <= w;
        reads++;
      end
    end
  end

  always @(negedge clk) begin
    if (fifo_q.size() == 0) i_empty = 1'b1;
  end

  // Per-cycle comparison against the scoreboard and the spec-level bookkeeping.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk("rst_rden", o_rden, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", o_busy, 0);
      prev_stall = 1'b0;
    end else begin
      chk("rden_while_empty", o_rden && i_empty, 0);
      chk("outstanding_le2", ((reads - done) + int'(o_rden)) <= 2, 1);
      chk("busy", o_busy, reads != done);
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_data);
        chk("stall_last", o_last, prev_last);
      end
      if (o_valid && i_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", o_data, e.d);
          chk("beat_last", o_last, e.l);
          if (e.l) done++;
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [31:0]  lit [4];
    logic [127:0] w0;
    logic [31:0]  held;
    int           n;
    int           pushed;

    reset   = 1'b0;
    i_ready = 1'b0;
    i_empty = 1'b1;
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_rden", o_rden, 0);
    step();
    step();
    reset = 1'b1;

    // 1: idle with an empty FIFO
    for (int c = 0; c < 20; c++) begin
      step();
      #2;
      chk("idle_rden", o_rden, 0);
      chk("idle_valid", o_valid, 0);
      chk("idle_busy", o_busy, 0);
    end

    // 2: single word, literal beat values and latency
    lit[0] = 32'h0000000A;
    lit[1] = 32'h0000000B;
    lit[2] = 32'h0000000C;
    lit[3] = 32'h0000000D;
    i_ready = 1'b1;
    step();
    push(128'h0000000D_0000000C_0000000B_0000000A);
    #2;
    chk("t2_rden_same_cycle", o_rden, 1);
    step();
    #2;
    chk("t2_rden_once", o_rden, 0);
    chk("t2_valid_lat", o_valid, 0);
    chk("t2_busy_inflight", o_busy, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      #2;
      chk("t2_valid", o_valid, 1);
      chk("t2_data", o_data, lit[k]);
      chk("t2_last", o_last, k == 3);
    end
    step();
    #2;
    chk("t2_valid_end", o_valid, 0);
    chk("t2_busy_end", o_busy, 0);
    chk("t2_one_read", reads, 1);

    // 3: eight back-to-back words, no bubbles
    step();
    for (int k = 0; k < 8; k++) push(rand_word());
    n = 0;
    while (!o_valid && n < 10) begin
      step();
      #2;
      n++;
    end
    chk("t3_first_valid", o_valid, 1);
    for (int c = 1; c < 32; c++) begin
      step();
      #2;
      chk("t3_no_bubble", o_valid, 1);
    end
    wait_drain(50);

    // 4: backpressure mid-word
    step();
    w0 = rand_word();
    push(w0);
    for (int k = 0; k < 3; k++) push(rand_word());
    n = 0;
    while (!o_valid && n < 10) begin
      step();
      #2;
      n++;
    end
    chk("t4_first_valid", o_valid, 1);
    step();
    i_ready = 1'b0;
    #2;
    held = o_data;
    chk("t4_held_is_beat1", held, w0[63:32]);
    for (int c = 0; c < 10; c++) begin
      step();
      #2;
      chk("t4_stall_data", o_data, held);
      chk("t4_stall_last", o_last, 0);
      chk("t4_stall_rden", o_rden, 0);
      chk("t4_stall_busy", o_busy, 1);
    end
    i_ready = 1'b1;
    wait_drain(60);

    // 5: random ready, 100 random words
    pushed = 0;
    n = 0;
    while (pushed < 100 && n < 5000) begin
      step();
      i_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        push(rand_word());
        pushed++;
      end
      n++;
    end
    chk("t5_all_pushed", pushed, 100);
    step();
    i_ready = 1'b1;
    wait_drain(1000);

    // 6: reset while presenting beat 2 with the next word in flight
    step();
    w0 = rand_word();
    push(w0);
    step();
    step();
    step();
    push(rand_word());
    step();
    #3;
    chk("t6_valid_before", o_valid, 1);
    chk("t6_beat2", o_data, w0[95:64]);
    chk("t6_busy_before", o_busy, 1);
    reset = 1'b0;
    #1;
    chk("t6_rden_rst", o_rden, 0);
    chk("t6_valid_rst", o_valid, 0);
    chk("t6_data_rst", o_data, 0);
    chk("t6_last_rst", o_last, 0);
    chk("t6_busy_rst", o_busy, 0);
    fifo_q.delete();
    exp_q.delete();
    reads   = 0;
    done    = 0;
    i_empty = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    push(rand_word());
    push(rand_word());
    wait_drain(50);
    step();
    #2;
    chk("t6_idle_after", o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
